// File: rtl/alu_pkg.sv
// Shared operation encoding for the execute-stage ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational WIDTH-bit ALU result for a single (a, b, op) triple.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] y
);

    logic slt;
    logic sltu;

    // Direct signed compare keeps SLT correct when a - b overflows.
    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, sltu};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered execute-stage ALU: one-cycle latency result and zero flag.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Y,
    output logic             Z
);

    logic [WIDTH-1:0] y_next;

    alu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .a (A),
        .b (B),
        .op(alu_op_t'(ALUControl)),
        .y (y_next)
    );

    // Z is derived from the same next value so it can never disagree with Y.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y <= '0;
            Z <= 1'b1;
        end else begin
            Y <= y_next;
            Z <= (y_next == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal cases plus randomized traffic vs a behavioural model.
module tb_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALUControl;
    logic [W-1:0] Y;
    logic         Z;

    int errors = 0;
    int checks = 0;

    logic         chk_en = 1'b0;
    logic [W-1:0] exp_y;
    logic         exp_z;

    alu #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .ALUControl(ALUControl),
        .Y         (Y),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint to_signed(input logic [W-1:0] v);
        longint u;
        u = longint'(v);
        return v[W-1] ? u - (64'sd1 <<< W) : u;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        longint ua;
        longint ub;
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: return W'((ua + ub) % (64'sd1 <<< W));
            3'd1: return W'((ua - ub + (64'sd1 <<< W)) % (64'sd1 <<< W));
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (to_signed(a) < to_signed(b)) ? W'(1) : W'(0);
            default: return (ua < ub) ? W'(1) : W'(0);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_y <= '0;
            exp_z <= 1'b1;
        end else begin
            exp_y <= model(A, B, ALUControl);
            exp_z <= (model(A, B, ALUControl) == '0);
        end
    end

    // Mid-cycle compare: outputs must still hold the value captured at the last edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (Y !== exp_y || Z !== exp_z) begin
                errors++;
                $display("FAIL model_cmp t=%0t Y=%h Z=%b required Y=%h Z=%b", $time, Y, Z, exp_y, exp_z);
            end
        end
    end

    task automatic do_op(input string name, input logic r, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ly, input logic lz);
        rst        = r;
        A          = a;
        B          = b;
        ALUControl = op;
        @(posedge clk);
        #1;
        checks++;
        if (Y !== ly || Z !== lz) begin
            errors++;
            $display("FAIL %s Y=%h Z=%b required Y=%h Z=%b", name, Y, Z, ly, lz);
        end
    endtask

    initial begin
        rst = 1'b0;
        A = '0;
        B = '0;
        ALUControl = 3'd0;
        @(posedge clk);
        #1;

        do_op("reset", 1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
        chk_en = 1'b1;

        do_op("add_25_100",   1'b0, 3'd0, 32'd25,        32'd100,       32'h0000007D, 1'b0);
        do_op("sub_333_1024", 1'b0, 3'd1, 32'd333,       32'd1024,      32'hFFFFFD4D, 1'b0);
        do_op("add_wrap",     1'b0, 3'd0, 32'hFFFFFFFF,  32'd1,         32'h0,        1'b1);
        do_op("and",          1'b0, 3'd2, 32'h0000F0F0,  32'h00000F0F,  32'h0,        1'b1);
        do_op("or",           1'b0, 3'd3, 32'h0000A0A0,  32'h00005F5F,  32'h0000FFFF, 1'b0);
        do_op("xor",          1'b0, 3'd4, 32'h00001212,  32'h00003232,  32'h00002020, 1'b0);
        do_op("nor",          1'b0, 3'd5, 32'h00002222,  32'h00002222,  32'hFFFFDDDD, 1'b0);
        do_op("slt_pos",      1'b0, 3'd6, 32'h0000F345,  32'h00007354,  32'h0,        1'b1);
        do_op("sltu_pos",     1'b0, 3'd7, 32'h0000F123,  32'h00007811,  32'h0,        1'b1);
        do_op("slt_minint",   1'b0, 3'd6, 32'h80000000,  32'd1,         32'h1,        1'b0);
        do_op("sltu_minint",  1'b0, 3'd7, 32'h80000000,  32'd1,         32'h0,        1'b1);
        do_op("slt_ovf",      1'b0, 3'd6, 32'h7FFFFFFF,  32'h80000000,  32'h0,        1'b1);

        do_op("b2b_add",  1'b0, 3'd0, 32'd12, 32'd10, 32'h00000016, 1'b0);
        do_op("b2b_sub",  1'b0, 3'd1, 32'd12, 32'd10, 32'h00000002, 1'b0);
        do_op("b2b_and",  1'b0, 3'd2, 32'd12, 32'd10, 32'h00000008, 1'b0);
        do_op("b2b_or",   1'b0, 3'd3, 32'd12, 32'd10, 32'h0000000E, 1'b0);
        do_op("b2b_xor",  1'b0, 3'd4, 32'd12, 32'd10, 32'h00000006, 1'b0);
        do_op("b2b_nor",  1'b0, 3'd5, 32'd12, 32'd10, 32'hFFFFFFF1, 1'b0);
        do_op("b2b_slt",  1'b0, 3'd6, 32'd12, 32'd10, 32'h00000000, 1'b1);
        do_op("b2b_sltu", 1'b0, 3'd7, 32'd10, 32'd12, 32'h00000001, 1'b0);

        do_op("rst_mid_sub",  1'b1, 3'd1, 32'd5, 32'd9, 32'h0,        1'b1);
        do_op("after_rst",    1'b0, 3'd0, 32'd3, 32'd4, 32'h00000007, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                2: rb = ra;
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            rst        = ($urandom_range(0, 24) == 0);
            A          = ra;
            B          = rb;
            ALUControl = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
